// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {instr, pc, pc+4} entries with
// fetch back-pressure, decode stall absorption and flush-on-redirect.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ValidF,
    input  logic [WIDTH-1:0]         InstrF,
    input  logic [WIDTH-1:0]         PCF,
    input  logic [WIDTH-1:0]         PCPlus4F,
    output logic                     ReadyF,
    input  logic                     FlushE,
    input  logic                     ReadyD,
    output logic                     ValidD,
    output logic [WIDTH-1:0]         InstrD,
    output logic [WIDTH-1:0]         PCD,
    output logic [WIDTH-1:0]         PCPlus4D,
    output logic [$clog2(DEPTH):0]   CountQ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] pc4_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Full blocks pushes even when a pop frees a slot in the same cycle.
    assign ReadyF = (count_q != CW'(DEPTH));
    assign ValidD = (count_q != '0);
    assign push   = ValidF & ReadyF & ~FlushE;
    assign pop    = ValidD & ReadyD & ~FlushE;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FlushE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the occupancy counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= InstrF;
            pc_mem[wr_ptr_q]    <= PCF;
            pc4_mem[wr_ptr_q]   <= PCPlus4F;
        end
    end

    always_comb begin
        InstrD   = WIDTH'(32'h0000_0013);
        PCD      = '0;
        PCPlus4D = '0;
        if (ValidD) begin
            InstrD   = instr_mem[rd_ptr_q];
            PCD      = pc_mem[rd_ptr_q];
            PCPlus4D = pc4_mem[rd_ptr_q];
        end
    end

    assign CountQ = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decode stage of the pipelined core. It captures each fetched instruction word with its PC and PC+4 and presents them to decode in order. It absorbs decode stalls without losing fetched words, back-pressures fetch through the fetch-stage enable, and discards all buffered entries when execute redirects the PC.

## Interface
Parameters
- WIDTH, 32, data/address width
- DEPTH, 4, number of entries; power of two, minimum 2

Ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- ValidF  in  1  fetch presents a valid word this cycle
- InstrF  in  WIDTH  instruction word from instruction memory
- PCF  in  WIDTH  PC of InstrF
- PCPlus4F  in  WIDTH  PCF + 4
- ReadyF  out  1  queue accepts a push this cycle; drives the fetch-stage `en`
- FlushE  in  1  PC redirect from execute; high whenever PCSrcE != 2'b00
- ReadyD  in  1  decode consumes the head this cycle; low means decode stall
- ValidD  out  1  head entry valid
- InstrD  out  WIDTH  head instruction; 32'h00000013 (NOP) when ValidD = 0
- PCD  out  WIDTH  head PC; 0 when ValidD = 0
- PCPlus4D  out  WIDTH  head PC+4; 0 when ValidD = 0
- CountQ  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries {InstrF, PCF, PCPlus4F}.
- Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH. A separate occupancy counter distinguishes full from empty.
- Push = ValidF & ReadyF & !FlushE.
- ReadyF = (CountQ != DEPTH). No pass-through when full: a push is refused in a full cycle even if a pop happens in that cycle.
- Pop = ValidD & ReadyD & !FlushE.
- Push and pop in the same cycle: both pointers advance and CountQ is unchanged.
- Flush:
  - When FlushE = 1, the next edge resets both pointers and CountQ to 0.
  - Any push or pop requested in that cycle is ignored.
  - Flush has absolute priority.
- Outputs:
  - ValidD = (CountQ != 0).
  - InstrD, PCD and PCPlus4D are read combinationally from the head entry when ValidD = 1, otherwise they show the NOP/zero values.
- No state machine beyond the pointers and counter. Entries are never reordered or duplicated.
- Reset (rst = 0, asynchronous):
  - Pointers and CountQ go to 0.
  - Outputs become ValidD = 0, InstrD = 32'h00000013, PCD = 0, PCPlus4D = 0, CountQ = 0, ReadyF = 1.
  - Storage contents need not be cleared.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing
- Latency: a word pushed at edge N appears at the decode outputs after edge N (empty-queue case), i.e. one cycle from fetch to decode. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle in steady state.
- Stall: with ReadyD = 0, the outputs stay stable across edges until a pop or a flush.
- Full: with CountQ = DEPTH, ReadyF = 0 in the same cycle, which freezes the fetch PC. ReadyF returns to 1 in the cycle after the first pop.
- Flush: ValidD = 0 and ReadyF = 1 in the cycle after FlushE. The redirected fetch word is pushed from that cycle onward.
- Wrap-around: pointer increment from DEPTH-1 goes to 0. A full-depth rotation must preserve FIFO order.
- Reset release: the first push is possible at the first rising edge after rst goes high.

## Test plan
- Reset: drive rst = 0 mid-stream with CountQ = 3. Required response: ValidD = 0, InstrD = 32'h00000013, CountQ = 0, ReadyF = 1 immediately. After release, push PCF = 0x0 and see PCD = 0x0 one cycle later.
- Streaming: push PCF = 0x0, 0x4, 0x8 … with ReadyD = 1 for 10 cycles. Required response: PCD follows one cycle behind and CountQ stays at 1. Repeat for more than DEPTH entries to exercise wrap-around.
- Stall-to-full: hold ReadyD = 0 and push PCF = 0x10, 0x14, 0x18, 0x1C.
  - After the 4th push: CountQ = 4, ReadyF = 0, and a 5th push of 0x20 is refused.
  - Release ReadyD: outputs PCD = 0x10, 0x14, 0x18, 0x1C, then 0x20 after fetch re-offers it.
- Simultaneous push/pop at CountQ = 2: CountQ stays 2 and the order is preserved.
- Flush: with 3 entries queued, assert FlushE together with ValidF (PCF = 0x40) and ReadyD = 1. Required response: next cycle ValidD = 0 and CountQ = 0, 0x40 is not stored, and the following push of PCF = 0x80 appears as the next PCD.
- Random: random ValidF/ReadyD/FlushE against a scoreboard model. Check order, no loss, no duplication, CountQ ≤ DEPTH.
